alu_decoder_md: RTL
===================

Name: alu_decoder_md

Overview:
Registered, parametrised successor to the combinational ALU decoder. It decodes the main-decoder ALUOp and the R-type funct field into an extended 4-bit ALU control word, covering add/sub/and/or/slt/xor/nor/shifts/lui. It also sequences multi-cycle multiply/divide operations: the block issues start/done strobes to the mult/div unit and applies a valid/ready back-pressure handshake to the issuing pipeline stage. It sits between the main decoder and the ALU/HI-LO unit in the datapath.

Parameters:
MULT_LAT, 4, cycles from MdStart to MdDone for mult/multu; legal range 1..255
DIV_LAT, 32, cycles from MdStart to MdDone for div/divu; legal range 1..255
CNT_W, 8, width of the latency counter; must satisfy 2^CNT_W > max(MULT_LAT, DIV_LAT)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
ValidIn  input  1  Op/F are valid this cycle
ReadyOut  output  1  block can accept an operation; combinational, high only in IDLE
Op  input  3  ALUOp: 000 add, 001 sub, 010 R-type, 011 and, 100 or, 101 slt, 110 xor, 111 lui
F  input  6  funct field; used only when Op=010
Flush  input  1  synchronous abort of an in-flight mult/div
Ctrl  output  4  registered ALU control word
ValidOut  output  1  Ctrl/flags valid; one-cycle pulse per accepted op
Illegal  output  1  pulses with ValidOut when an R-type funct is undefined
MdStart  output  1  one-cycle start strobe to the mult/div unit
MdIsDiv  output  1  registered: 1 = div/divu, 0 = mult/multu; held while busy
MdSigned  output  1  registered: 1 = signed variant; held while busy
MdDone  output  1  one-cycle pulse; HI/LO write enable
Busy  output  1  high in MUL or DIV state

Behaviour:
- Ctrl encoding: and 0000, or 0001, add 0010, xor 0011, nor 0100, sub 0110, slt 0111, sll 1000, srl 1001, sra 1010, lui 1011. Bit 3 is 0 for the legacy 3-bit ops.
- R-type funct map:
  - 0x20/0x21 add
  - 0x22/0x23 sub
  - 0x24 and, 0x25 or, 0x26 xor, 0x27 nor, 0x2A slt
  - 0x00 sll, 0x02 srl, 0x03 sra
  - 0x18 mult, 0x19 multu, 0x1A div, 0x1B divu
  - all others: Illegal=1 and Ctrl=0010.
- Mult/div functs drive Ctrl=0010 (don't-care for the ALU) and start the MD sequence.
- No X is ever driven on any output.
- Accept condition: ValidIn & ReadyOut. Outputs register on that edge, so there is 1-cycle latency from accept to ValidOut.
- ValidIn while ReadyOut=0 is ignored. The source must hold the operation.
- Ctrl holds its last value when no accept occurs.
- FSM states: IDLE, MUL, DIV.
  - IDLE: accepting mult/multu sets cnt=MULT_LAT-1 and moves to MUL; accepting div/divu sets cnt=DIV_LAT-1 and moves to DIV. MdStart and ValidOut pulse on the next cycle, and MdIsDiv/MdSigned latch.
  - MUL/DIV: cnt decrements each cycle. When cnt==0, MdDone pulses for one cycle and the FSM returns to IDLE on that edge.
  - MdDone therefore asserts exactly LAT cycles after MdStart.
  - ReadyOut is high in the same cycle MdDone is high, because the FSM is back in IDLE.
- Flush in MUL/DIV: return to IDLE next edge with no MdDone. Flush in IDLE has no effect.
- Flush and cnt==0 in the same cycle: Flush wins, so MdDone is suppressed.
- reset (any time, including mid-sequence): state=IDLE, cnt=0, and Ctrl=0000, ValidOut=0, Illegal=0, MdStart=0, MdIsDiv=0, MdSigned=0, MdDone=0, Busy=0 immediately (asynchronous). ReadyOut=1 after reset.
- Back-to-back non-MD ops are accepted every cycle at full throughput.

Test Plan:
- Reset, then Op=010 F=0x22 ValidIn=1 -> next cycle Ctrl=0110, ValidOut=1, Illegal=0; Op=000 on the following cycle -> Ctrl=0010.
- Every Op value 011..111 and every defined funct (0x27 -> 0100, 0x03 -> 1010, 0x2A -> 0111, ...) -> encoding per table; F=0x3F -> Illegal=1, Ctrl=0010.
- mult (F=0x18) with MULT_LAT=4 -> MdStart at t+1, MdSigned=1, Busy t+1..t+4, MdDone at t+5, ReadyOut low t+1..t+4; a second op held on ValidIn is accepted at t+5.
- divu (F=0x1B), DIV_LAT=32 -> MdIsDiv=1, MdSigned=0, MdDone exactly 32 cycles after MdStart.
- div, then Flush at busy cycle 10 -> IDLE next cycle, no MdDone ever; Flush coincident with cnt==0 -> no MdDone.
- reset asserted mid-DIV between clock edges -> all outputs 0 immediately; after release ReadyOut=1 and the next mult runs a clean full MULT_LAT sequence.

Source files
------------

// File: rtl/alu_decoder_md_if.sv
// Bus between the issuing pipeline stage / mult-div unit and the ALU decoder.
// The master side issues operations and consumes the decoded control and MD strobes.
interface alu_decoder_md_if;
    logic       ValidIn;
    logic       ReadyOut;
    logic [2:0] Op;
    logic [5:0] F;
    logic       Flush;
    logic [3:0] Ctrl;
    logic       ValidOut;
    logic       Illegal;
    logic       MdStart;
    logic       MdIsDiv;
    logic       MdSigned;
    logic       MdDone;
    logic       Busy;

    modport master (
        output ValidIn, Op, F, Flush,
        input  ReadyOut, Ctrl, ValidOut, Illegal, MdStart, MdIsDiv, MdSigned, MdDone, Busy
    );

    modport slave (
        input  ValidIn, Op, F, Flush,
        output ReadyOut, Ctrl, ValidOut, Illegal, MdStart, MdIsDiv, MdSigned, MdDone, Busy
    );
endinterface

// File: rtl/alu_decoder_md.sv
// Registered ALU control decoder that also sequences multi-cycle mult/div
// operations, holding off the issuing stage while the MD unit is busy.
module alu_decoder_md #(
    parameter int MULT_LAT = 4,
    parameter int DIV_LAT  = 32,
    parameter int CNT_W    = 8
) (
    input  logic               clk,
    input  logic               reset,
    alu_decoder_md_if.slave    bus
);

    localparam logic [3:0] C_AND = 4'b0000;
    localparam logic [3:0] C_OR  = 4'b0001;
    localparam logic [3:0] C_ADD = 4'b0010;
    localparam logic [3:0] C_XOR = 4'b0011;
    localparam logic [3:0] C_NOR = 4'b0100;
    localparam logic [3:0] C_SUB = 4'b0110;
    localparam logic [3:0] C_SLT = 4'b0111;
    localparam logic [3:0] C_SLL = 4'b1000;
    localparam logic [3:0] C_SRL = 4'b1001;
    localparam logic [3:0] C_SRA = 4'b1010;
    localparam logic [3:0] C_LUI = 4'b1011;

    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

    typedef struct packed {
        logic [3:0] ctrl;
        logic       ill;
        logic       md;
        logic       is_div;
        logic       sgn;
    } dec_t;

    // Undefined functs and mult/div both fall back to add so the ALU sees a benign op.
    function automatic dec_t decode(input logic [2:0] op, input logic [5:0] f);
        dec_t d;
        d      = '0;
        d.ctrl = C_ADD;
        case (op)
            3'b000: d.ctrl = C_ADD;
            3'b001: d.ctrl = C_SUB;
            3'b011: d.ctrl = C_AND;
            3'b100: d.ctrl = C_OR;
            3'b101: d.ctrl = C_SLT;
            3'b110: d.ctrl = C_XOR;
            3'b111: d.ctrl = C_LUI;
            default: begin
                case (f)
                    6'h20, 6'h21: d.ctrl = C_ADD;
                    6'h22, 6'h23: d.ctrl = C_SUB;
                    6'h24:        d.ctrl = C_AND;
                    6'h25:        d.ctrl = C_OR;
                    6'h26:        d.ctrl = C_XOR;
                    6'h27:        d.ctrl = C_NOR;
                    6'h2A:        d.ctrl = C_SLT;
                    6'h00:        d.ctrl = C_SLL;
                    6'h02:        d.ctrl = C_SRL;
                    6'h03:        d.ctrl = C_SRA;
                    6'h18: begin d.md = 1'b1; d.sgn = 1'b1; end
                    6'h19: begin d.md = 1'b1; end
                    6'h1A: begin d.md = 1'b1; d.is_div = 1'b1; d.sgn = 1'b1; end
                    6'h1B: begin d.md = 1'b1; d.is_div = 1'b1; end
                    default: d.ill = 1'b1;
                endcase
            end
        endcase
        return d;
    endfunction

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             start_n, done_n;
    logic             accept;
    dec_t             dec;

    logic [3:0]       ctrl_p1;
    logic             vld_p1, ill_p1, start_p1, isdiv_p1, sgn_p1, done_p1;

    assign bus.ReadyOut = (state == IDLE);
    assign bus.Busy     = (state != IDLE);
    assign accept       = bus.ValidIn & bus.ReadyOut;
    assign dec          = decode(bus.Op, bus.F);

    // Flush takes priority over the terminal count so an aborted op never writes HI/LO.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        start_n = 1'b0;
        done_n  = 1'b0;
        case (state)
            IDLE: begin
                if (accept && dec.md) begin
                    start_n = 1'b1;
                    if (dec.is_div) begin
                        state_n = DIV;
                        cnt_n   = CNT_W'(DIV_LAT - 1);
                    end else begin
                        state_n = MUL;
                        cnt_n   = CNT_W'(MULT_LAT - 1);
                    end
                end
            end
            MUL, DIV: begin
                if (bus.Flush) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else if (cnt == '0) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    // Stage p1: decoded control and MD strobes, one cycle after accept.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            ctrl_p1  <= '0;
            vld_p1   <= 1'b0;
            ill_p1   <= 1'b0;
            start_p1 <= 1'b0;
            isdiv_p1 <= 1'b0;
            sgn_p1   <= 1'b0;
            done_p1  <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            vld_p1   <= accept;
            ill_p1   <= accept & dec.ill;
            start_p1 <= start_n;
            done_p1  <= done_n;
            if (accept) ctrl_p1 <= dec.ctrl;
            if (start_n) begin
                isdiv_p1 <= dec.is_div;
                sgn_p1   <= dec.sgn;
            end
        end
    end

    assign bus.Ctrl     = ctrl_p1;
    assign bus.ValidOut = vld_p1;
    assign bus.Illegal  = ill_p1;
    assign bus.MdStart  = start_p1;
    assign bus.MdIsDiv  = isdiv_p1;
    assign bus.MdSigned = sgn_p1;
    assign bus.MdDone   = done_p1;

endmodule
